// File: rtl/unidade_controle_pkg.sv
// Shared codes for the processor control path: opcodes, bus selector codes,
// ALU operations and FSM states. Also used by the bus multiplexer and ALU.
package unidade_controle_pkg;

  typedef enum logic [2:0] {
    OP_MV   = 3'd0,
    OP_MVI  = 3'd1,
    OP_ADD  = 3'd2,
    OP_SUB  = 3'd3,
    OP_LD   = 3'd4,
    OP_ST   = 3'd5,
    OP_MVNZ = 3'd6,
    OP_SLT  = 3'd7
  } opcode_e;

  // Bus selector codes 0-7 address R0-R7; R7 is the program counter
  localparam logic [3:0] SEL_PC   = 4'd7;
  localparam logic [3:0] SEL_DIN  = 4'd8;
  localparam logic [3:0] SEL_G    = 4'd9;
  localparam logic [3:0] SEL_ZERO = 4'd10;
  localparam logic [3:0] SEL_ONE  = 4'd11;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_SLT = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_F0, S_F1, S_F2, S_T1, S_T2, S_T3, S_T4
  } state_e;

  function automatic logic [3:0] sel_reg(input logic [2:0] r);
    return {1'b0, r};
  endfunction

  function automatic logic [1:0] alu_of(input opcode_e op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/unidade_controle_decodificador_3x8.sv
// 3-to-8 one-hot decoder with enable; drives the register load enables.
module decodificador_3x8 (
  input  logic [2:0] w_i,
  input  logic       en_i,
  output logic [7:0] y_o
);

  always_comb begin
    y_o = 8'd0;
    if (en_i) y_o[w_i] = 1'b1;
  end

endmodule

// File: rtl/unidade_controle.sv
// Multi-cycle control unit: fetch (F0-F2) then execute (T1-T3), with outputs
// decoded from the registered state and instruction register.
module unidade_controle
  import unidade_controle_pkg::*;
#(
  parameter int OPW = 3
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Run,
  input  logic [15:0] DIN,
  input  logic        Gnz,
  output logic [3:0]  sel,
  output logic [7:0]  Rin,
  output logic        Ain,
  output logic        Gin,
  output logic        IRin,
  output logic        ADDRin,
  output logic        DOUTin,
  output logic        W_D,
  output logic        incr_pc,
  output logic [1:0]  alu_op,
  output logic        Done
);

  state_e         state_q, state_d;
  logic [15:0]    ir_q;
  logic [OPW-1:0] op_raw;
  opcode_e        op;
  logic [2:0]     x, y;
  logic           rin_en;

  assign op_raw = ir_q[15 -: OPW];
  assign op     = opcode_e'(op_raw);
  assign x      = ir_q[12:10];
  assign y      = ir_q[9:7];

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      ir_q    <= 16'd0;
    end else begin
      state_q <= state_d;
      if (IRin) ir_q <= DIN;
    end
  end

  // Run is only sampled in IDLE and on the Done cycle, so dropping it
  // mid-instruction lets the instruction finish.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (Run) state_d = S_F0;
      S_F0:   state_d = S_F1;
      S_F1:   state_d = S_F2;
      S_F2:   state_d = S_T1;
      S_T1: begin
        if (op == OP_MV || op == OP_MVNZ) state_d = Run ? S_F0 : S_IDLE;
        else                              state_d = S_T2;
      end
      S_T2:   state_d = S_T3;
      S_T3:   state_d = Run ? S_F0 : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sel     = SEL_ZERO;
    rin_en  = 1'b0;
    Ain     = 1'b0;
    Gin     = 1'b0;
    IRin    = 1'b0;
    ADDRin  = 1'b0;
    DOUTin  = 1'b0;
    W_D     = 1'b0;
    incr_pc = 1'b0;
    alu_op  = ALU_ADD;
    Done    = 1'b0;
    case (state_q)
      S_F0: begin
        sel     = SEL_PC;
        ADDRin  = 1'b1;
        incr_pc = 1'b1;
      end
      S_F2: IRin = 1'b1;
      S_T1: begin
        case (op)
          OP_MV: begin
            sel    = sel_reg(y);
            rin_en = 1'b1;
            Done   = 1'b1;
          end
          OP_MVNZ: begin
            Done = 1'b1;
            if (Gnz) begin
              sel    = sel_reg(y);
              rin_en = 1'b1;
            end
          end
          OP_MVI: begin
            sel     = SEL_PC;
            ADDRin  = 1'b1;
            incr_pc = 1'b1;
          end
          OP_LD, OP_ST: begin
            sel    = sel_reg(y);
            ADDRin = 1'b1;
          end
          default: begin
            sel = sel_reg(x);
            Ain = 1'b1;
          end
        endcase
      end
      S_T2: begin
        case (op)
          OP_ADD, OP_SUB, OP_SLT: begin
            sel    = sel_reg(y);
            Gin    = 1'b1;
            alu_op = alu_of(op);
          end
          OP_ST: begin
            sel    = sel_reg(x);
            DOUTin = 1'b1;
          end
          default: ;
        endcase
      end
      S_T3: begin
        case (op)
          OP_MVI, OP_LD: begin
            sel    = SEL_DIN;
            rin_en = 1'b1;
            Done   = 1'b1;
          end
          OP_ST: begin
            W_D  = 1'b1;
            Done = 1'b1;
          end
          OP_ADD, OP_SUB, OP_SLT: begin
            sel    = SEL_G;
            rin_en = 1'b1;
            Done   = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  decodificador_3x8 u_dec (
    .w_i  (x),
    .en_i (rin_en),
    .y_o  (Rin)
  );

endmodule

// File: tb/tb_unidade_controle.sv
// Scoreboard bench: each instruction's per-cycle output pattern is queued
// when it is issued and compared cycle by cycle as the control unit runs.
module tb_unidade_controle;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic        Run = 1'b0;
  logic [15:0] DIN = 16'd0;
  logic        Gnz = 1'b0;
  logic [3:0]  sel;
  logic [7:0]  Rin;
  logic        Ain, Gin, IRin, ADDRin, DOUTin, W_D, incr_pc, Done;
  logic [1:0]  alu_op;

  int          checks = 0;
  int          errors = 0;
  int          incr_cnt = 0;
  int          done_at = 0;
  logic        last_done = 1'b0;
  string       cur_name = "";
  logic [21:0] sb[$];
  logic [21:0] exp_tmp[$];

  unidade_controle #(.OPW(3)) dut (
    .Clock(Clock), .Resetn(Resetn), .Run(Run), .DIN(DIN), .Gnz(Gnz),
    .sel(sel), .Rin(Rin), .Ain(Ain), .Gin(Gin), .IRin(IRin),
    .ADDRin(ADDRin), .DOUTin(DOUTin), .W_D(W_D), .incr_pc(incr_pc),
    .alu_op(alu_op), .Done(Done)
  );

  always #5 Clock = ~Clock;

  function automatic logic [21:0] mk(input logic [3:0] s, input logic [7:0] r,
      input logic a, input logic g, input logic ir, input logic ad,
      input logic dout, input logic wd, input logic inc, input logic [1:0] alu,
      input logic dn);
    return {s, r, a, g, ir, ad, dout, wd, inc, alu, dn};
  endfunction

  function automatic logic [21:0] idle_v();
    return mk(4'd10, 8'd0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0);
  endfunction

  function automatic logic [15:0] enc(input int op, input int x, input int y);
    logic [15:0] w;
    w = 16'd0;
    w[15:13] = op[2:0];
    w[12:10] = x[2:0];
    w[9:7]   = y[2:0];
    return w;
  endfunction

  // Reference cycle patterns for one instruction, fetch included
  function automatic void gen(input logic [15:0] ins, input logic gnz);
    logic [2:0] op, x, y;
    logic [7:0] rx;
    logic [1:0] alu;
    op = ins[15:13];
    x  = ins[12:10];
    y  = ins[9:7];
    rx = 8'd1 << x;
    alu = (op == 3'd3) ? 2'd1 : (op == 3'd7) ? 2'd2 : 2'd0;
    exp_tmp.delete();
    exp_tmp.push_back(mk(4'd7, 8'd0, 0, 0, 0, 1, 0, 0, 1, 2'd0, 0));
    exp_tmp.push_back(idle_v());
    exp_tmp.push_back(mk(4'd10, 8'd0, 0, 0, 1, 0, 0, 0, 0, 2'd0, 0));
    case (op)
      3'd0: exp_tmp.push_back(mk({1'b0, y}, rx, 0, 0, 0, 0, 0, 0, 0, 2'd0, 1));
      3'd6: exp_tmp.push_back(gnz ? mk({1'b0, y}, rx, 0, 0, 0, 0, 0, 0, 0, 2'd0, 1)
                                  : mk(4'd10, 8'd0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 1));
      3'd1: begin
        exp_tmp.push_back(mk(4'd7, 8'd0, 0, 0, 0, 1, 0, 0, 1, 2'd0, 0));
        exp_tmp.push_back(idle_v());
        exp_tmp.push_back(mk(4'd8, rx, 0, 0, 0, 0, 0, 0, 0, 2'd0, 1));
      end
      3'd4: begin
        exp_tmp.push_back(mk({1'b0, y}, 8'd0, 0, 0, 0, 1, 0, 0, 0, 2'd0, 0));
        exp_tmp.push_back(idle_v());
        exp_tmp.push_back(mk(4'd8, rx, 0, 0, 0, 0, 0, 0, 0, 2'd0, 1));
      end
      3'd5: begin
        exp_tmp.push_back(mk({1'b0, y}, 8'd0, 0, 0, 0, 1, 0, 0, 0, 2'd0, 0));
        exp_tmp.push_back(mk({1'b0, x}, 8'd0, 0, 0, 0, 0, 1, 0, 0, 2'd0, 0));
        exp_tmp.push_back(mk(4'd10, 8'd0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 1));
      end
      default: begin
        exp_tmp.push_back(mk({1'b0, x}, 8'd0, 1, 0, 0, 0, 0, 0, 0, 2'd0, 0));
        exp_tmp.push_back(mk({1'b0, y}, 8'd0, 0, 1, 0, 0, 0, 0, 0, alu, 0));
        exp_tmp.push_back(mk(4'd9, rx, 0, 0, 0, 0, 0, 0, 0, 2'd0, 1));
      end
    endcase
  endfunction

  task automatic step();
    logic [21:0] act, e;
    @(posedge Clock);
    #1;
    act = {sel, Rin, Ain, Gin, IRin, ADDRin, DOUTin, W_D, incr_pc, alu_op, Done};
    last_done = Done;
    if (incr_pc === 1'b1) incr_cnt++;
    checks++;
    if (sel > 4'd11 || !$onehot0(Rin) || (incr_pc && Rin[7])) begin
      errors++;
      $display("FAIL %s invariant: sel=%0d Rin=%b incr_pc=%b", cur_name, sel, Rin, incr_pc);
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty: got %h", cur_name, act);
    end else begin
      e = sb.pop_front();
      if (act !== e) begin
        errors++;
        $display("FAIL %s outputs: got %h expected %h", cur_name, act, e);
      end
    end
  endtask

  task automatic expect_idle(input int n);
    for (int i = 0; i < n; i++) begin
      sb.push_back(idle_v());
      step();
    end
  endtask

  // Issues one instruction; ncheck>0 stops after that many cycles
  task automatic drive_instr(input logic [15:0] ins, input logic gnz,
                             input logic run_after, input int ncheck);
    int n;
    DIN = ins;
    Gnz = gnz;
    Run = 1'b1;
    gen(ins, gnz);
    n = (ncheck == 0) ? exp_tmp.size() : ncheck;
    for (int i = 0; i < n; i++) sb.push_back(exp_tmp[i]);
    done_at = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (i == 0) Run = run_after;
      if (last_done === 1'b1 && done_at == 0) done_at = i + 1;
    end
    if (ncheck == 0 && !run_after) expect_idle(1);
  endtask

  task automatic test_reset();
    cur_name = "reset";
    Resetn = 1'b0;
    Run = 1'b0;
    expect_idle(2);
    Resetn = 1'b1;
    cur_name = "idle_run0";
    expect_idle(5);
  endtask

  task automatic test_reset_release_run();
    cur_name = "release_run";
    Resetn = 1'b0;
    Run = 1'b1;
    expect_idle(1);
    Resetn = 1'b1;
    cur_name = "mv_r7_r2";
    drive_instr(enc(0, 7, 2), 1'b0, 1'b0, 0);
  endtask

  task automatic test_add();
    cur_name = "add_r1_r2";
    drive_instr(enc(2, 1, 2), 1'b0, 1'b0, 0);
    checks++;
    if (done_at + 1 != 7) begin
      errors++;
      $display("FAIL add_latency: got %0d cycles expected 7", done_at + 1);
    end
  endtask

  task automatic test_mvnz();
    cur_name = "mvnz_gnz0";
    drive_instr(enc(6, 3, 4), 1'b0, 1'b0, 0);
    cur_name = "mvnz_gnz1";
    drive_instr(enc(6, 3, 4), 1'b1, 1'b0, 0);
  endtask

  task automatic test_mem_alu();
    cur_name = "st_r5_r6";
    drive_instr(enc(5, 5, 6), 1'b0, 1'b0, 0);
    cur_name = "ld_r0_r3";
    drive_instr(enc(4, 0, 3), 1'b0, 1'b0, 0);
    cur_name = "slt_r6_r1";
    drive_instr(enc(7, 6, 1), 1'b0, 1'b0, 0);
    cur_name = "sub_r2_r5";
    drive_instr(enc(3, 2, 5), 1'b0, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    cur_name = "b2b_mvi";
    incr_cnt = 0;
    drive_instr(enc(1, 1, 0), 1'b0, 1'b1, 0);
    drive_instr(enc(1, 2, 0), 1'b0, 1'b1, 0);
    drive_instr(enc(1, 7, 0), 1'b0, 1'b0, 0);
    checks++;
    if (incr_cnt != 6) begin
      errors++;
      $display("FAIL b2b_incr_pc: got %0d pulses expected 6", incr_cnt);
    end
  endtask

  task automatic test_reset_mid();
    cur_name = "sub_reset_t2";
    drive_instr(enc(3, 1, 2), 1'b0, 1'b1, 5);
    Resetn = 1'b0;
    cur_name = "reset_mid";
    expect_idle(1);
    Resetn = 1'b1;
    Run = 1'b0;
    cur_name = "after_reset_mid";
    expect_idle(2);
  endtask

  initial begin
    test_reset();
    test_reset_release_run();
    test_add();
    test_mvnz();
    test_mem_alu();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/unidade_controle.md
UNIDADE_CONTROLE -- requirements
Module: unidade_controle

Interface
REQ-001 The block SHALL have parameter OPW, default 3, meaning opcode width, fixed by the ISA.
REQ-002 The block SHALL have one clock; reset is synchronous and active-low.
- Clock  in  1  rising-edge clock
- Resetn  in  1  synchronous active-low reset
- Run  in  1  start/continue execution
- DIN  in  16  memory read data; instruction word when IRin is asserted
- Gnz  in  1  G register non-zero flag
- sel  out  4  bus selector: 0-7 R0-R7, 8 DIN, 9 G, 10 constant 0, 11 constant 1
- Rin  out  8  one-hot register load enables for R0-R7
- Ain, Gin, IRin, ADDRin, DOUTin, W_D, incr_pc  out  1 each  load/strobe enables
- alu_op  out  2  ALU operation: 0 add, 1 sub, 2 slt
- Done  out  1  one-cycle pulse on the final cycle of an instruction

Function
REQ-003 The block SHALL hold an internal 16-bit IR, loaded from DIN when IRin is asserted; decode fields are op=IR[15:13], X=IR[12:10], Y=IR[9:7].
REQ-004 The block SHALL decode op as 0 mv, 1 mvi, 2 add, 3 sub, 4 ld, 5 st, 6 mvnz, 7 slt.
REQ-005 The FSM SHALL have states IDLE, F0, F1, F2, T1, T2, T3, T4.
REQ-006 IDLE: all enables 0, sel=10; when Run=1, go to F0.
REQ-007 F0: sel=7, ADDRin=1, incr_pc=1; go to F1.
REQ-008 F1: memory wait with no enables; go to F2.
REQ-009 F2: IRin=1; go to T1.
REQ-010 mv: in T1, sel=Y, Rin[X]=1, Done=1.
REQ-011 mvnz: in T1, if Gnz=1, behave as mv; else no enables and Done=1.
REQ-012 mvi:
- T1: sel=7, ADDRin=1, incr_pc=1.
- T2: wait.
- T3: sel=8, Rin[X]=1, Done=1.
REQ-013 add/sub/slt:
- T1: sel=X, Ain=1.
- T2: sel=Y, Gin=1, alu_op=0/1/2.
- T3: sel=9, Rin[X]=1, Done=1.
REQ-014 ld:
- T1: sel=Y, ADDRin=1.
- T2: wait.
- T3: sel=8, Rin[X]=1, Done=1.
REQ-015 st:
- T1: sel=Y, ADDRin=1.
- T2: sel=X, DOUTin=1.
- T3: W_D=1, Done=1.
REQ-016 After the Done cycle, the FSM SHALL go to F0 if Run=1, else to IDLE.
REQ-017 Outputs SHALL be registered-state Moore decodes.
REQ-018 In every state and cycle, sel SHALL never exceed 11.
REQ-019 At most one Rin bit SHALL be set in any cycle.
REQ-020 Unlisted enables SHALL be 0 and unlisted sel SHALL be 10.
REQ-021 Run deasserting mid-instruction SHALL NOT abort the instruction; the instruction completes.
REQ-022 Writes with X=7 SHALL overwrite the PC and take effect for the next fetch.
REQ-023 incr_pc and Rin[7] SHALL never be asserted together.
REQ-024 Done SHALL pulse exactly once per instruction.

Reset
REQ-025 On a rising Clock edge with Resetn=0, the block SHALL set state=IDLE, IR=0, and all outputs 0 except sel=10; the same edge SHALL NOT assert Done.
REQ-026 Reset asserted mid-instruction SHALL abandon the instruction with no further enables.
REQ-027 The first cycle with Resetn=1 SHALL evaluate Run from IDLE.

Structure
REQ-028 Opcode codes, sel codes (SEL_DIN=8, SEL_G=9, SEL_ZERO=10, SEL_ONE=11) and alu_op codes SHALL live in a shared package, also used by the bus multiplexer and ALU.
REQ-029 The FSM and output decode SHALL stay in one module.
REQ-030 One sub-module, decodificador_3x8, SHALL produce the one-hot Rin from X.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- Reset, Run=0 for 5 cycles -> state IDLE, sel=10, all enables 0, no Done.
- Run=1, DIN=0x2000|X=1|Y=2 (add R1,R2) -> F0,F1,F2,T1 Ain sel=1, T2 Gin sel=2 alu_op=0, T3 sel=9 Rin=0x02 Done; 7 cycles total.
- mvnz R3,R4 with Gnz=0 -> Done in T1, Rin=0; same with Gnz=1 -> sel=4, Rin=0x08.
- st R5,[R6] -> T1 sel=6 ADDRin, T2 sel=5 DOUTin, T3 W_D=1 Done.
- Run held high over 3 back-to-back mvi -> F0 follows each Done directly; incr_pc pulses 6 times.
- Resetn=0 during T2 of sub -> next cycle IDLE, no Gin/Rin, no Done.
